// File: rtl/if_fetch.sv
// Instruction fetch stage with integrated IF/ID latch and one-entry skid buffer.
// One outstanding memory request; redirects during a wait retire the stale fetch first.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    typedef enum logic [1:0] {FETCH, FULL, KILL} state_t;

    state_t      state;
    logic [31:0] pc_reg, pending_pc, buf_pc, buf_inst;

    // Request depends only on registered state, never on the ack.
    assign rom_req_o  = !rst && (state == FETCH || state == KILL);
    assign rom_addr_o = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc_reg       <= RESET_PC;
            pending_pc   <= '0;
            buf_pc       <= '0;
            buf_inst     <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else if (redirect_i) begin
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
            buf_pc       <= '0;
            buf_inst     <= '0;
            case (state)
                FETCH: begin
                    if (rom_ack_i) begin
                        pc_reg <= redirect_pc_i;
                    end else begin
                        pending_pc <= redirect_pc_i;
                        state      <= KILL;
                    end
                end
                FULL: begin
                    pc_reg <= redirect_pc_i;
                    state  <= FETCH;
                end
                default: pending_pc <= redirect_pc_i;
            endcase
        end else if (flush_i) begin
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
            case (state)
                FULL: begin
                    // Refetch the dropped buffered instruction.
                    pc_reg   <= buf_pc;
                    buf_pc   <= '0;
                    buf_inst <= '0;
                    state    <= FETCH;
                end
                KILL: begin
                    if (rom_ack_i) begin
                        pc_reg <= pending_pc;
                        state  <= FETCH;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (rom_ack_i) begin
                        pc_reg <= pc_reg + PC_STEP;
                        if (stall_i) begin
                            buf_pc   <= pc_reg;
                            buf_inst <= rom_data_i;
                            state    <= FULL;
                        end else begin
                            pc_o         <= pc_reg;
                            inst_o       <= rom_data_i;
                            inst_valid_o <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        pc_o         <= '0;
                        inst_o       <= '0;
                        inst_valid_o <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall_i) begin
                        pc_o         <= buf_pc;
                        inst_o       <= buf_inst;
                        inst_valid_o <= 1'b1;
                        buf_pc       <= '0;
                        buf_inst     <= '0;
                        state        <= FETCH;
                    end
                end
                default: begin
                    if (rom_ack_i) begin
                        pc_reg <= pending_pc;
                        state  <= FETCH;
                    end
                    if (!stall_i) begin
                        pc_o         <= '0;
                        inst_o       <= '0;
                        inst_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Random-stimulus bench for if_fetch against a queue-based model of the fetch stream.
module tb_if_fetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, redirect_i, rom_ack_i;
    logic [31:0] redirect_pc_i, rom_data_i;
    logic        rom_req_o, inst_valid_o;
    logic [31:0] rom_addr_o, pc_o, inst_o;

    if_fetch #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i),
        .rom_data_i(rom_data_i), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: next address to fetch, fetched-but-undelivered words, and a
    // pending "discard one stale response, then jump" obligation.
    logic [31:0] m_pc, m_tgt, o_pc, o_inst;
    logic        m_kill, o_v;
    logic [63:0] q[$];

    task automatic m_bubble();
        o_pc = '0; o_inst = '0; o_v = 1'b0;
    endtask

    initial begin
        logic        m_req, got, r, st, fl, rd;
        logic [31:0] rpc, data;
        logic [63:0] e;
        m_pc = '0; m_tgt = '0; m_kill = 1'b0; o_pc = '0; o_inst = '0; o_v = 1'b0;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = '0; rom_ack_i = 1'b0; rom_data_i = '0;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            chk("pc_o", pc_o, o_pc);
            chk("inst_o", inst_o, o_inst);
            chk("inst_valid_o", inst_valid_o, o_v);

            m_req = m_kill || (q.size() == 0);
            if (cyc < 2) begin
                r = 1'b1; st = 1'b0; fl = 1'b0; rd = 1'b0;
            end else if (cyc < 40) begin
                // zero-wait, no hazards: one instruction per cycle
                r = 1'b0; st = 1'b0; fl = 1'b0; rd = 1'b0;
            end else begin
                r  = ($urandom_range(99) < 2);
                st = ($urandom_range(99) < 30);
                fl = ($urandom_range(99) < 6);
                rd = ($urandom_range(99) < 8);
            end
            case ($urandom_range(3))
                0: rpc = 32'h0000_0100;
                1: rpc = 32'hFFFF_FFF8;
                2: rpc = 32'h0000_0040;
                default: rpc = {$urandom_range(255), 2'b00};
            endcase
            data = m_pc ^ K;
            rst = r; stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
            if (r) rom_ack_i = $urandom_range(1);     // late ack during reset
            else if (!m_req) rom_ack_i = 1'b0;
            else if (cyc < 40) rom_ack_i = 1'b1;
            else rom_ack_i = ($urandom_range(99) < 55);
            rom_data_i = rom_ack_i ? data : $urandom;
            #1;
            chk("rom_req_o", rom_req_o, !r && m_req);
            if (!r && m_req) chk("rom_addr_o", rom_addr_o, m_pc);
            got = !r && m_req && rom_ack_i;

            if (r) begin
                m_pc = '0; m_kill = 1'b0; m_tgt = '0; q.delete(); m_bubble();
            end else if (rd) begin
                m_bubble();
                if (m_kill) m_tgt = rpc;
                else if (got || q.size() != 0) m_pc = rpc;
                else begin m_kill = 1'b1; m_tgt = rpc; end
                q.delete();
            end else if (fl) begin
                m_bubble();
                if (m_kill) begin
                    if (got) begin m_pc = m_tgt; m_kill = 1'b0; end
                end else if (q.size() != 0) begin
                    m_pc = q[0][63:32];
                    q.delete();
                end
            end else if (m_kill) begin
                if (got) begin m_pc = m_tgt; m_kill = 1'b0; end
                if (!st) m_bubble();
            end else if (q.size() != 0) begin
                if (!st) begin
                    e = q.pop_front();
                    o_pc = e[63:32]; o_inst = e[31:0]; o_v = 1'b1;
                end
            end else if (got) begin
                if (st) q.push_back({m_pc, data});
                else begin o_pc = m_pc; o_inst = data; o_v = 1'b1; end
                m_pc = m_pc + 32'd4;
            end else if (!st) begin
                m_bubble();
            end
            @(posedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage with an integrated IF/ID pipeline latch. It sits directly upstream of the decode stage and drives that stage's pc_i/inst_i inputs.
It owns the PC and talks to instruction memory through a one-outstanding req/ack handshake that tolerates variable latency. It honours stall, flush and branch redirect from downstream, and buffers one instruction that arrives while decode is stalled.

Parameters:
RESET_PC, 32'h00000000, PC value fetched first after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous and active-high (1'b1 = RstEnable)
stall_i  in  1  downstream cannot accept; IF/ID outputs hold
flush_i  in  1  squash IF/ID contents and any in-flight/buffered instruction
redirect_i  in  1  branch/jump taken; fetch continues at redirect_pc_i
redirect_pc_i  in  32  redirect target address
rom_req_o  out  1  fetch request to instruction memory
rom_addr_o  out  32  fetch address; stable while rom_req_o=1 and no ack
rom_ack_i  in  1  memory returns data this cycle (same-cycle ack allowed)
rom_data_i  in  32  instruction word, valid when rom_ack_i=1
pc_o  out  32  IF/ID latched PC, to decode pc_i
inst_o  out  32  IF/ID latched instruction, to decode inst_i
inst_valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at edge): pc_reg=RESET_PC, state=FETCH, pc_o=0, inst_o=0, inst_valid_o=0, buffer empty, pending_pc=0. rom_req_o=0 while rst=1.
- Invalid IF/ID is a bubble: inst_o=32'h0 (NOP), pc_o=0, inst_valid_o=0.
- rom_req_o = (state is FETCH or KILL) and rst=0. rom_addr_o = pc_reg. It is decoded from registered state only, with no combinational path from rom_ack_i.
- State FETCH:
  - ack & !stall: IF/ID <= {pc_reg, rom_data_i, valid=1}; pc_reg += PC_STEP; stay FETCH. Back-to-back fetches give 1 instruction per cycle on zero-wait memory.
  - ack & stall: IF/ID holds; buffer <= {pc_reg, rom_data_i}; pc_reg += PC_STEP; go FULL.
  - !ack & !stall: IF/ID <= bubble.
  - !ack & stall: IF/ID holds.
- State FULL (rom_req_o=0):
  - !stall: IF/ID <= buffer; buffer cleared; go FETCH.
  - stall: hold.
- State KILL: a stale request is outstanding and its address must stay stable until acked.
  - ack: data discarded; pc_reg <= pending_pc; go FETCH.
  - IF/ID follows the stall rule with no new data: bubble if !stall, hold if stall.
- Redirect (priority over stall), all states:
  - IF/ID <= bubble and buffer cleared.
  - FETCH with ack, or FULL: pc_reg <= redirect_pc_i; go FETCH, and the new request issues next cycle. Data acked in that cycle is discarded.
  - FETCH without ack: pending_pc <= redirect_pc_i; go KILL.
  - KILL: pending_pc <= redirect_pc_i; stay KILL. The last redirect wins.
- Flush without redirect:
  - IF/ID <= bubble.
  - Data acked this cycle is discarded and pc_reg is not advanced, so that address is refetched.
  - FULL: buffer dropped; pc_reg <= buffered PC; go FETCH.
  - Otherwise the state is unchanged.
- Priority: rst > redirect > flush > stall.
- PC arithmetic: 32-bit unsigned and wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0). No alignment check.
- Reset mid-transaction: state returns to FETCH at RESET_PC. Any late ack arriving while rst=1 is ignored. Memory must drop outstanding requests on the same reset.

Test Plan:
- Zero-wait memory returns inst = addr ^ 32'hA5A50000 from RESET_PC=0, ack tied to req -> after reset, IF/ID shows pc 0,4,8,C on consecutive cycles with inst_valid_o=1.
- 2-cycle-latency memory -> rom_addr_o stable during the wait; IF/ID shows a bubble (inst_o=0, valid=0) between instructions; pc sequence 0,4,8.
- stall_i=1 for 3 cycles while ack arrives at pc=8 -> IF/ID holds pc=4, rom_req_o=0 during FULL; stall release gives pc=8 next cycle, then the request for C.
- redirect_i with redirect_pc_i=32'h100 while pc=C is waiting for ack -> state KILL, pc=C data discarded at ack; next rom_addr_o=32'h100; IF/ID shows bubbles until pc=100.
- flush_i alone while state FULL with buffered pc=8 -> buffer dropped, IF/ID bubble, refetch at 8.
- rst asserted mid-wait at pc=14 with a late ack -> outputs reset to 0, ack ignored, first post-reset rom_addr_o=RESET_PC; pc=32'hFFFFFFFC followed by 0 at the wrap.
